// File: rtl/dft_in_framer_if.sv
// Sample stream into the framer plus the framed sink bus and status towards the DFT core.
// master = framer side; slave = surrounding logic (sample source, DFT core, config/status).
interface dft_in_framer_if #(
    parameter int DW = 18,
    parameter int PW = 12
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_real;
    logic [DW-1:0] in_imag;
    logic [PW-1:0] cfg_dftpts;
    logic          cfg_inverse;
    logic          sink_valid;
    logic          sink_ready;
    logic          sink_sop;
    logic          sink_eop;
    logic [DW-1:0] sink_real;
    logic [DW-1:0] sink_imag;
    logic [PW-1:0] dftpts_in;
    logic          inverse;
    logic          err_cfg;
    logic [15:0]   frame_cnt;

    modport master (
        input  in_valid, in_real, in_imag, cfg_dftpts, cfg_inverse, sink_ready,
        output in_ready, sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
               dftpts_in, inverse, err_cfg, frame_cnt
    );

    modport slave (
        output in_valid, in_real, in_imag, cfg_dftpts, cfg_inverse, sink_ready,
        input  in_ready, sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
               dftpts_in, inverse, err_cfg, frame_cnt
    );
endinterface

// File: rtl/dft_in_framer.sv
// Cuts an unframed complex sample stream into DFT frames; 1-cycle input-to-sink latency through one
// output register, in_ready drops while that register is stalled by sink_ready and outside STREAM.
module dft_in_framer #(
    parameter int DW      = 18,
    parameter int PW      = 12,
    parameter int MIN_PTS = 12,
    parameter int MAX_PTS = 1296,
    parameter int GAP_MIN = 16
) (
    input  logic            clk,
    input  logic            rst,
    dft_in_framer_if.master bus
);
    localparam int GW = $clog2(GAP_MIN + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, GAP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pts_q, pts_d;
    logic          inv_q, inv_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   fcnt_q, fcnt_d;
    logic          err_q, err_d;
    logic          vld_q, vld_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;
    logic [DW-1:0] re_q, re_d;
    logic [DW-1:0] im_q, im_d;

    logic cfg_legal;
    logic accept;
    logic in_hs;
    logic out_hs;
    logic last;

    assign cfg_legal = (bus.cfg_dftpts >= PW'(MIN_PTS)) && (bus.cfg_dftpts <= PW'(MAX_PTS))
                    && ((bus.cfg_dftpts % PW'(12)) == '0);
    // A new sample may enter only when the output register is empty or draining this cycle.
    assign accept    = (state_q == STREAM) && (!vld_q || bus.sink_ready);
    assign in_hs     = accept && bus.in_valid;
    assign out_hs    = vld_q && bus.sink_ready;
    assign last      = (cnt_q == (pts_q - PW'(1)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pts_d   = pts_q;
        inv_d   = inv_q;
        gap_d   = gap_q;
        fcnt_d  = fcnt_q;
        err_d   = 1'b0;
        vld_d   = vld_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        re_d    = re_q;
        im_d    = im_q;

        if (in_hs) begin
            vld_d = 1'b1;
            sop_d = (cnt_q == '0);
            eop_d = last;
            re_d  = bus.in_real;
            im_d  = bus.in_imag;
        end else if (out_hs) begin
            vld_d = 1'b0;
            sop_d = 1'b0;
            eop_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (cfg_legal) begin
                        pts_d   = bus.cfg_dftpts;
                        inv_d   = bus.cfg_inverse;
                        cnt_d   = '0;
                        state_d = STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (in_hs) begin
                    cnt_d = cnt_q + PW'(1);
                    if (last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Only the eop beat can be pending here, so any output handshake closes the frame.
                if (out_hs) begin
                    fcnt_d  = fcnt_q + 16'd1;
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(GAP_MIN - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pts_q   <= '0;
            inv_q   <= 1'b0;
            gap_q   <= '0;
            fcnt_q  <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pts_q   <= pts_d;
            inv_q   <= inv_d;
            gap_q   <= gap_d;
            fcnt_q  <= fcnt_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    assign bus.in_ready   = accept;
    assign bus.sink_valid = vld_q;
    assign bus.sink_sop   = sop_q;
    assign bus.sink_eop   = eop_q;
    assign bus.sink_real  = re_q;
    assign bus.sink_imag  = im_q;
    assign bus.dftpts_in  = pts_q;
    assign bus.inverse    = inv_q;
    assign bus.err_cfg    = err_q;
    assign bus.frame_cnt  = fcnt_q;
endmodule

// File: tb/tb_dft_in_framer.sv
// Directed bench for dft_in_framer: ramp frames, backpressure, illegal config, mid-frame cfg change,
// back-to-back gap timing and mid-frame reset, checked with immediate assertions.
module tb_dft_in_framer;
    localparam int DW = 18;
    localparam int PW = 12;

    typedef struct {
        logic          sop;
        logic          eop;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [PW-1:0] pts;
        logic          inv;
        logic [15:0]   fc;
        int            cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dft_in_framer_if #(.DW(DW), .PW(PW)) bus ();

    dft_in_framer #(
        .DW(DW), .PW(PW), .MIN_PTS(12), .MAX_PTS(1296), .GAP_MIN(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    lat_err = 0;
    int    hold_err = 0;
    int    rdy_err = 0;
    int    step_no = 0;
    int    rdy_mode = 0;
    logic [3:0] rdy_pat = 4'b1001;
    beat_t q[$];

    // Every sink handshake is logged with the cycle it occurred in.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus.sink_valid && bus.sink_ready)
            q.push_back('{sop: bus.sink_sop, eop: bus.sink_eop, re: bus.sink_real, im: bus.sink_imag,
                          pts: bus.dftpts_in, inv: bus.inverse, fc: bus.frame_cnt, cyc: cyc});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(output bit acc);
        logic            pre_stall;
        logic [DW-1:0]   pre_dat;
        logic [2*DW+1:0] snap;
        if (bus.sink_valid === 1'b1 && bus.sink_ready === 1'b0 && bus.in_ready !== 1'b0) rdy_err++;
        acc       = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
        pre_stall = (bus.sink_valid === 1'b1) && (bus.sink_ready === 1'b0);
        pre_dat   = bus.in_real;
        snap      = {bus.sink_sop, bus.sink_eop, bus.sink_real, bus.sink_imag};
        @(posedge clk);
        #1;
        if (pre_stall && snap !== {bus.sink_sop, bus.sink_eop, bus.sink_real, bus.sink_imag}) hold_err++;
        if (acc && !(bus.sink_valid === 1'b1 && bus.sink_real === pre_dat)) lat_err++;
        step_no++;
        bus.sink_ready = (rdy_mode == 0) ? 1'b1 : rdy_pat[2'(step_no % 4)];
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic drive(input int n, input int base, input int chg_at,
                         input logic [PW-1:0] chg_pts, input logic chg_inv, input string tag);
        int idx = 0;
        int guard = 0;
        bit acc;
        while (idx < n && guard < 5000) begin
            if (idx == chg_at) begin
                bus.cfg_dftpts  = chg_pts;
                bus.cfg_inverse = chg_inv;
            end
            bus.in_valid = 1'b1;
            bus.in_real  = DW'(base + idx);
            bus.in_imag  = DW'(-(base + idx));
            tick(acc);
            if (acc) idx++;
            guard++;
        end
        chk({tag, "_accepted"}, 32'(idx), 32'(n));
    endtask

    task automatic drain(input int target, input string tag);
        int guard = 0;
        bit acc;
        while (q.size() < target && guard < 300) begin
            tick(acc);
            guard++;
        end
        chk({tag, "_beat_count"}, 32'(q.size()), 32'(target));
    endtask

    task automatic check_frame(input int qi, input int n, input int d0,
                               input logic [PW-1:0] pts, input logic inv, input string tag);
        int e = 0;
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b = q[qi + i];
            if (b.sop !== (i == 0) || b.eop !== (i == n - 1) || b.re !== DW'(d0 + i)
                || b.im !== DW'(-(d0 + i)) || b.pts !== pts || b.inv !== inv) e++;
        end
        chk({tag, "_beat_errors"}, 32'(e), 32'd0);
        chk({tag, "_first_sop"}, 32'(q[qi].sop), 32'd1);
        chk({tag, "_last_eop"}, 32'(q[qi + n - 1].eop), 32'd1);
    endtask

    initial begin
        bit acc;
        int q0, q1, q2, q3, q4, q5, q6;
        int guard, hi_cyc, errs, rdys, vlds;

        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_real     = '0;
        bus.in_imag     = '0;
        bus.cfg_dftpts  = '0;
        bus.cfg_inverse = 1'b0;
        bus.sink_ready  = 1'b1;
        idle(3);
        chk("rst_sink_valid", 32'(bus.sink_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_sop_eop", 32'({bus.sink_sop, bus.sink_eop}), 32'd0);
        chk("rst_data", 32'(bus.sink_real | bus.sink_imag), 32'd0);
        chk("rst_dftpts_inv", 32'({bus.dftpts_in, bus.inverse}), 32'd0);
        chk("rst_err_cfg", 32'(bus.err_cfg), 32'd0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        rst = 1'b0;
        idle(2);

        // Basic 1200-pt frame, then in_valid stays high with a 12-pt config queued.
        bus.cfg_dftpts  = 12'd1200;
        bus.cfg_inverse = 1'b0;
        q0 = q.size();
        drive(1200, 0, -1, '0, 1'b0, "basic");
        bus.cfg_dftpts = 12'd12;
        drain(q0 + 1200, "basic");
        check_frame(q0, 1200, 0, 12'd1200, 1'b0, "basic");
        chk("basic_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        chk("basic_latency_errs", 32'(lat_err), 32'd0);
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            tick(acc);
            guard++;
        end
        hi_cyc = cyc;
        chk("basic_in_ready_gap", 32'(hi_cyc - q[q0 + 1199].cyc), 32'd18);

        // Two 12-pt frames with in_valid held high throughout.
        q1 = q.size();
        drive(12, 100, -1, '0, 1'b0, "b2b_a");
        drain(q1 + 12, "b2b_a");
        drive(12, 200, -1, '0, 1'b0, "b2b_b");
        bus.in_valid = 1'b0;
        drain(q1 + 24, "b2b_b");
        check_frame(q1, 12, 100, 12'd12, 1'b0, "b2b_a");
        check_frame(q1 + 12, 12, 200, 12'd12, 1'b0, "b2b_b");
        chk("b2b_sop_spacing_ge18", 32'((q[q1 + 12].cyc - q[q1 + 11].cyc) >= 18), 32'd1);
        chk("b2b_frame_cnt", 32'(bus.frame_cnt), 32'd3);
        idle(30);

        // 24-pt frame with sink_ready cycling 1,0,0,1.
        rdy_mode = 1;
        hold_err = 0;
        rdy_err  = 0;
        lat_err  = 0;
        bus.cfg_dftpts = 12'd24;
        q2 = q.size();
        drive(24, 300, -1, '0, 1'b0, "bp");
        bus.in_valid = 1'b0;
        drain(q2 + 24, "bp");
        check_frame(q2, 24, 300, 12'd24, 1'b0, "bp");
        chk("bp_hold_errs", 32'(hold_err), 32'd0);
        chk("bp_in_ready_errs", 32'(rdy_err), 32'd0);
        chk("bp_latency_errs", 32'(lat_err), 32'd0);
        rdy_mode = 0;
        idle(30);

        // Illegal 1000-pt request for three cycles, then a legal 12-pt frame.
        bus.cfg_dftpts = 12'd1000;
        errs = 0;
        rdys = 0;
        vlds = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = (i < 3);
            if (bus.in_ready === 1'b1) rdys++;
            tick(acc);
            if (bus.err_cfg === 1'b1) errs++;
            if (bus.sink_valid === 1'b1) vlds++;
        end
        chk("illegal_err_pulses", 32'(errs), 32'd3);
        chk("illegal_in_ready", 32'(rdys), 32'd0);
        chk("illegal_sink_valid", 32'(vlds), 32'd0);
        bus.cfg_dftpts = 12'd12;
        q3 = q.size();
        drive(12, 400, -1, '0, 1'b0, "after_illegal");
        bus.in_valid = 1'b0;
        drain(q3 + 12, "after_illegal");
        check_frame(q3, 12, 400, 12'd12, 1'b0, "after_illegal");
        chk("after_illegal_frame_cnt", 32'(bus.frame_cnt), 32'd5);
        idle(30);

        // 36-pt inverse frame; config switched to 48/forward at sample 10.
        bus.cfg_dftpts  = 12'd36;
        bus.cfg_inverse = 1'b1;
        q4 = q.size();
        drive(36, 500, 10, 12'd48, 1'b0, "midcfg");
        bus.in_valid = 1'b0;
        drain(q4 + 36, "midcfg");
        check_frame(q4, 36, 500, 12'd36, 1'b1, "midcfg");
        idle(30);
        q5 = q.size();
        drive(48, 600, -1, '0, 1'b0, "next48");
        bus.in_valid = 1'b0;
        drain(q5 + 48, "next48");
        check_frame(q5, 48, 600, 12'd48, 1'b0, "next48");
        chk("next48_frame_cnt", 32'(bus.frame_cnt), 32'd7);
        idle(30);

        // Reset after 500 samples of a 1200-pt frame.
        bus.cfg_dftpts  = 12'd1200;
        bus.cfg_inverse = 1'b1;
        drive(500, 700, -1, '0, 1'b0, "rstmid");
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick(acc);
        chk("rstmid_sink_valid", 32'(bus.sink_valid), 32'd0);
        chk("rstmid_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rstmid_sop_eop", 32'({bus.sink_sop, bus.sink_eop}), 32'd0);
        chk("rstmid_data", 32'(bus.sink_real | bus.sink_imag), 32'd0);
        chk("rstmid_dftpts_inv", 32'({bus.dftpts_in, bus.inverse}), 32'd0);
        chk("rstmid_err_cfg", 32'(bus.err_cfg), 32'd0);
        chk("rstmid_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        rst = 1'b0;
        tick(acc);
        bus.cfg_dftpts  = 12'd12;
        bus.cfg_inverse = 1'b0;
        q6 = q.size();
        drive(12, 900, -1, '0, 1'b0, "post_rst");
        bus.in_valid = 1'b0;
        drain(q6 + 12, "post_rst");
        check_frame(q6, 12, 900, 12'd12, 1'b0, "post_rst");
        chk("post_rst_cnt_at_sop", 32'(q[q6].fc), 32'd0);
        chk("post_rst_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
